alu_share_arb: RTL
==================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning operand and result width.
REQ-002 The block SHALL have parameter OPCODE_LENGTH, default 4, meaning ALU Operation code width.
REQ-003 The block SHALL have the following ports; each requester port reqN/rspN exists for N = 0 and N = 1:
- clk, input, 1: single clock; all state on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- reqN_valid, input, 1: requester N presents an operation.
- reqN_ready, output, 1: the operation is accepted this cycle.
- reqN_a, input, DATA_WIDTH: operand A.
- reqN_b, input, DATA_WIDTH: operand B.
- reqN_op, input, OPCODE_LENGTH: ALU operation code.
- rspN_valid, output, 1: result buffer N is full.
- rspN_ready, input, 1: requester N consumes the result.
- rspN_result, output, DATA_WIDTH: result.
- rspN_err, output, 1: the operation used an unsupported opcode.
- alu_srca, output, DATA_WIDTH: drives the shared ALU SrcA.
- alu_srcb, output, DATA_WIDTH: drives the shared ALU SrcB.
- alu_op, output, OPCODE_LENGTH: drives the shared ALU Operation.
- alu_result, input, DATA_WIDTH: combinational ALUResult from the shared ALU.

Function
REQ-004 An operation is transferred when reqN_valid && reqN_ready in the same cycle, and a result is transferred when rspN_valid && rspN_ready in the same cycle.
REQ-005 At most one request SHALL be granted per cycle. The granted port's a/b/op SHALL drive alu_srca/alu_srcb/alu_op combinationally in that cycle. When no port is granted, alu_srca, alu_srcb and alu_op SHALL all be 0.
REQ-006 Port N is eligible when reqN_valid=1 and its response buffer is empty or is being drained this cycle (rspN_valid && rspN_ready).
REQ-007 reqN_ready SHALL be 1 only for the granted port, and it SHALL NOT depend combinationally on reqN_valid of the other port beyond arbitration.
REQ-008 On grant, alu_result SHALL be registered into buffer N at the next clock edge. rspN_valid rises one cycle after acceptance (latency 1), and throughput is 1 operation per cycle overall.
REQ-009 Each buffer holds 1 entry. rspN_result, rspN_err and rspN_valid SHALL hold stable while rspN_valid && !rspN_ready.
REQ-010 Supported opcodes are 0000 through 1101. Opcodes 1110 and 1111 SHALL be accepted, with alu_op forced to 0000, rspN_result=0 and rspN_err=1. Supported opcodes produce rspN_err=0.
REQ-011 The arbiter SHALL hold a 1-bit priority pointer prio. Behaviour is defined in REQ-016/REQ-017.
REQ-012 When the buffer is drained and refilled in the same cycle, rspN_valid SHALL stay 1 and carry the new result.
REQ-013 Backpressure on port 0's response SHALL NOT block grants to port 1, and backpressure on port 1's response SHALL NOT block grants to port 0.

Reset
REQ-014 Asserting reset SHALL asynchronously clear rsp0_valid, rsp1_valid, rspN_result, rspN_err and prio, and SHALL make req0_ready=req1_ready=0. Any in-flight operation is discarded.
REQ-015 After deassertion, the first grant SHALL be possible in the first clock edge cycle.

Configuration
REQ-016 With macro ALU_SHARE_ARB_RR_EN defined, both valid and eligible SHALL grant port prio, and prio SHALL toggle to the non-granted port after every grant.
REQ-017 Without ALU_SHARE_ARB_RR_EN, port 0 SHALL always win ties, and prio SHALL be constant 0.

Structure
REQ-018 Package alu_share_arb_pkg SHALL hold the ALU opcode enum (AND, OR, ADD, SUB, XOR, SLL, SRL, SRA, EQ, SLT, BGE, BLT, BNE, JALR), the constants OP_ILLEGAL_MIN=4'b1110 and NUM_REQ=2, and the function op_supported().
REQ-019 A per-port sub-module alu_rsp_buf, 1-entry with valid/ready and asynchronous reset, SHALL be instantiated twice.

Verification
REQ-020 Reset release; req0 only, a=5, b=3, op=0010 -> req0_ready=1 in cycle 0; rsp0_valid=1, rsp0_result=8, rsp0_err=0 in cycle 1.
REQ-021 Both valid every cycle with rsp ready held 1 and RR_EN defined -> grants alternate 0,1,0,1 and prio starts at 0. Without RR_EN -> port 0 is granted every cycle.
REQ-022 rsp0_ready=0 with rsp0_valid=1 and req0 valid -> req0_ready=0, port 1 is still granted, and rsp0_result stays stable.
REQ-023 req1 op=1111, a=7, b=9 -> rsp1_err=1, rsp1_result=0, alu_op=0000 in the grant cycle.
REQ-024 Reset asserted while rsp1_valid=1 -> rsp1_valid=0 immediately, without waiting for clk.
REQ-025 Back-to-back drain and refill on port 0 (SUB a=2, b=5) -> rsp0_valid stays 1 and the result becomes 32'hFFFFFFFD.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// Opcode encoding and shared constants for the two-port ALU arbiter.
// Opcodes at or above OP_ILLEGAL_MIN are accepted but flagged as errors.
package alu_share_arb_pkg;

   localparam int OP_W    = 4;
   localparam int NUM_REQ = 2;

   typedef enum logic [OP_W-1:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_EQ   = 4'b1000,
      ALU_SLT  = 4'b1001,
      ALU_BGE  = 4'b1010,
      ALU_BLT  = 4'b1011,
      ALU_BNE  = 4'b1100,
      ALU_JALR = 4'b1101
   } alu_op_e;

   localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'b1110;

   function automatic logic op_supported(input logic [OP_W-1:0] op);
      return op < OP_ILLEGAL_MIN;
   endfunction

endpackage

// File: rtl/alu_share_arb_rsp.sv
// alu_rsp_buf: one-entry result buffer; loads on write, empties when the consumer takes it.
// Contents hold stable while valid and not ready; a same-cycle drain+write keeps it full.
module alu_rsp_buf #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_vld_i,
   input  logic [DATA_WIDTH-1:0] wr_result_i,
   input  logic                  wr_err_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_result_o,
   output logic                  rsp_err_o
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic                  err;
   } rsp_t;

   logic valid_q, valid_d;
   rsp_t dat_q, dat_d;

   always_comb begin
      valid_d = valid_q;
      dat_d   = dat_q;
      if (wr_vld_i) begin
         valid_d = 1'b1;
         dat_d   = '{result: wr_result_i, err: wr_err_i};
      end else if (rsp_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         dat_q   <= '0;
      end else begin
         valid_q <= valid_d;
         dat_q   <= dat_d;
      end
   end

   assign rsp_valid_o  = valid_q;
   assign rsp_result_o = dat_q.result;
   assign rsp_err_o    = dat_q.err;

endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates two requesters onto one combinational ALU; results land in per-port buffers one cycle later.
// A full, undrained buffer only blocks its own port. Round-robin enabled by ALU_SHARE_ARB_RR_EN.
module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [DATA_WIDTH-1:0]    req0_a,
   input  logic [DATA_WIDTH-1:0]    req0_b,
   input  logic [OPCODE_LENGTH-1:0] req0_op,
   output logic                     rsp0_valid,
   input  logic                     rsp0_ready,
   output logic [DATA_WIDTH-1:0]    rsp0_result,
   output logic                     rsp0_err,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [DATA_WIDTH-1:0]    req1_a,
   input  logic [DATA_WIDTH-1:0]    req1_b,
   input  logic [OPCODE_LENGTH-1:0] req1_op,
   output logic                     rsp1_valid,
   input  logic                     rsp1_ready,
   output logic [DATA_WIDTH-1:0]    rsp1_result,
   output logic                     rsp1_err,
   output logic [DATA_WIDTH-1:0]    alu_srca,
   output logic [DATA_WIDTH-1:0]    alu_srcb,
   output logic [OPCODE_LENGTH-1:0] alu_op,
   input  logic [DATA_WIDTH-1:0]    alu_result
);

   logic [NUM_REQ-1:0]       elig;
   logic [NUM_REQ-1:0]       gnt;
   logic [DATA_WIDTH-1:0]    sel_a, sel_b;
   logic [OPCODE_LENGTH-1:0] sel_op;
   logic                     sel_ok;
   logic [DATA_WIDTH-1:0]    wr_result;
   logic                     wr_err;

   // A port may issue when its buffer is free or is being emptied this same cycle.
   assign elig[0] = req0_valid && (!rsp0_valid || rsp0_ready);
   assign elig[1] = req1_valid && (!rsp1_valid || rsp1_ready);

`ifdef ALU_SHARE_ARB_RR_EN
   logic prio_q, prio_d;

   always_comb begin
      gnt    = '0;
      prio_d = prio_q;
      if (!reset) begin
         if (elig[0] && elig[1]) begin
            gnt[prio_q] = 1'b1;
         end else begin
            gnt = elig;
         end
      end
      if (|gnt) begin
         prio_d = gnt[0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end
`else
   always_comb begin
      gnt = '0;
      if (!reset) begin
         if (elig[0]) begin
            gnt[0] = 1'b1;
         end else if (elig[1]) begin
            gnt[1] = 1'b1;
         end
      end
   end
`endif

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      if (gnt[0]) begin
         sel_a  = req0_a;
         sel_b  = req0_b;
         sel_op = req0_op;
      end else if (gnt[1]) begin
         sel_a  = req1_a;
         sel_b  = req1_b;
         sel_op = req1_op;
      end
   end

   // Unsupported opcodes still occupy the ALU slot but present AND and store a zero result.
   assign sel_ok    = op_supported(sel_op[OP_W-1:0]) && ((sel_op >> OP_W) == '0);
   assign alu_srca  = sel_a;
   assign alu_srcb  = sel_b;
   assign alu_op    = sel_ok ? sel_op : '0;
   assign wr_result = sel_ok ? alu_result : '0;
   assign wr_err    = !sel_ok;

   alu_rsp_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_buf0 (
      .clk          (clk),
      .reset        (reset),
      .wr_vld_i     (gnt[0]),
      .wr_result_i  (wr_result),
      .wr_err_i     (wr_err),
      .rsp_valid_o  (rsp0_valid),
      .rsp_ready_i  (rsp0_ready),
      .rsp_result_o (rsp0_result),
      .rsp_err_o    (rsp0_err)
   );

   alu_rsp_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_buf1 (
      .clk          (clk),
      .reset        (reset),
      .wr_vld_i     (gnt[1]),
      .wr_result_i  (wr_result),
      .wr_err_i     (wr_err),
      .rsp_valid_o  (rsp1_valid),
      .rsp_ready_i  (rsp1_ready),
      .rsp_result_o (rsp1_result),
      .rsp_err_o    (rsp1_err)
   );

endmodule
